// File: rtl/sequenciador_multiciclo_pkg.sv
// Shared definitions for the multicycle RV32 sequencer: the estado bus codes,
// the supported opcodes and the latched opcode class.
package sequenciador_multiciclo_pkg;

  typedef enum logic [3:0] {
    ST_IF     = 4'b0000,
    ST_ID     = 4'b0001,
    ST_EX     = 4'b0010,
    ST_MEM    = 4'b0011,
    ST_WB     = 4'b0100,
    ST_AUX_EX = 4'b0101,
    ST_AUX_WB = 4'b0110,
    ST_SUMPC  = 4'b1000,
    ST_FIM    = 4'b1001,
    ST_PAUSE  = 4'b1010,
    ST_IDLE   = 4'b1011
  } estado_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_LOAD   = 3'd1,
    CL_STORE  = 3'd2,
    CL_ALU_R  = 3'd3,
    CL_ALU_I  = 3'd4,
    CL_BRANCH = 3'd5
  } classe_t;

  function automatic classe_t decode_classe(input logic [31:0] instr);
    classe_t c;
    case (instr[6:0])
      OP_LOAD:   c = CL_LOAD;
      OP_STORE:  c = CL_STORE;
      OP_ALU_R:  c = CL_ALU_R;
      OP_ALU_I:  c = CL_ALU_I;
      OP_BRANCH: c = CL_BRANCH;
      default:   c = CL_NONE;
    endcase
    return c;
  endfunction

  // Where an instruction goes once its execute stage (and settle wait) is done.
  function automatic estado_t pos_ex(input classe_t c);
    estado_t s;
    case (c)
      CL_LOAD, CL_STORE: s = ST_MEM;
      CL_ALU_R, CL_ALU_I: s = ST_WB;
      CL_BRANCH: s = ST_SUMPC;
      default: s = ST_FIM;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sequenciador_multiciclo_contador_espera.sv
// Settle-wait counter for the AUX_EX / AUX_WB states: load, count down, flag zero.
module contador_espera (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] valor,
  input  logic       dec,
  output logic [3:0] cnt,
  output logic       zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= valor;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Opcode-aware sequencer driving the shared estado bus of the multicycle RV32
// datapath, with start/halt, single-step pause and performance counters.
module sequenciador_multiciclo
  import sequenciador_multiciclo_pkg::*;
#(
  parameter int EX_WAIT = 2,
  parameter int WB_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instrucao,
  input  logic        step_en,
  input  logic        step_req,
  output logic [3:0]  estado,
  output logic        halted,
  output logic        illegal,
  output logic        paused,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
);

  // Control handshake: start is a level looked at only in IDLE; step_req is a
  // one-cycle pulse that only has effect while in PAUSE (ignored elsewhere).

  localparam logic [3:0] EX_LOAD = (EX_WAIT > 0) ? 4'(EX_WAIT - 1) : 4'd0;
  localparam logic [3:0] WB_LOAD = (WB_WAIT > 0) ? 4'(WB_WAIT - 1) : 4'd0;

  estado_t    state, next;
  classe_t    classe;
  logic       illegal_set;
  logic       wait_load, wait_dec, wait_zero;
  logic [3:0] wait_valor, wait_cnt;
  logic       running;

  always_comb begin
    next        = state;
    illegal_set = 1'b0;
    case (state)
      ST_IDLE:   if (start) next = ST_IF;
      ST_IF:     next = ST_ID;
      ST_ID: begin
        if (instrucao == 32'd0) begin
          next = ST_FIM;
        end else if (decode_classe(instrucao) == CL_NONE) begin
          next        = ST_FIM;
          illegal_set = 1'b1;
        end else begin
          next = ST_EX;
        end
      end
      ST_EX:     next = (EX_WAIT > 0) ? ST_AUX_EX : pos_ex(classe);
      ST_AUX_EX: if (wait_zero) next = pos_ex(classe);
      ST_MEM:    next = (classe == CL_LOAD) ? ST_WB : ST_SUMPC;
      ST_WB:     next = (WB_WAIT > 0) ? ST_AUX_WB : ST_SUMPC;
      ST_AUX_WB: if (wait_zero) next = ST_SUMPC;
      ST_SUMPC:  next = step_en ? ST_PAUSE : ST_IF;
      ST_PAUSE:  if (step_req || !step_en) next = ST_IF;
      ST_FIM:    next = ST_FIM;
      default: begin
        next        = ST_FIM;
        illegal_set = 1'b1;
      end
    endcase
  end

  // The counter is loaded only on entry to an AUX state, then counts down while there.
  always_comb begin
    wait_load  = ((next == ST_AUX_EX) && (state != ST_AUX_EX)) ||
                 ((next == ST_AUX_WB) && (state != ST_AUX_WB));
    wait_valor = (next == ST_AUX_EX) ? EX_LOAD : WB_LOAD;
    wait_dec   = (state == ST_AUX_EX) || (state == ST_AUX_WB);
    running    = (state != ST_IDLE) && (state != ST_PAUSE) && (state != ST_FIM);
  end

  contador_espera u_espera (
    .clk   (clk),
    .rst   (rst),
    .load  (wait_load),
    .valor (wait_valor),
    .dec   (wait_dec),
    .cnt   (wait_cnt),
    .zero  (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      classe      <= CL_NONE;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      paused      <= 1'b0;
      instr_count <= 32'd0;
      cycle_count <= 32'd0;
    end else begin
      state  <= next;
      halted <= (next == ST_FIM);
      paused <= (next == ST_PAUSE);
      if (state == ST_ID) classe <= decode_classe(instrucao);
      if (illegal_set) illegal <= 1'b1;
      if (state == ST_SUMPC) instr_count <= instr_count + 32'd1;
      if (running) cycle_count <= cycle_count + 32'd1;
    end
  end

  assign estado = state;

endmodule
